// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game sequencer and the pixel generator:
// state encodings, score digit layout and the default frame-tick divider.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned DEFAULT_TICK_DIV = 1_666_667;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } score_t;

  // Two-digit BCD increment that sticks at 99.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    r = s;
    if (s.ones == DIGIT_W'(9)) begin
      if (s.tens != DIGIT_W'(9)) begin
        r.tens = s.tens + DIGIT_W'(1);
        r.ones = '0;
      end
    end else begin
      r.ones = s.ones + DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running frame tick: counts 0..TICK_DIV-1 and emits a registered
// one-cycle pulse in the cycle after the count reaches TICK_DIV-1.
module pong_tick_gen
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CNT_LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer: serve/freeze control, ball reloads, lives and BCD score.
//  state   | meaning
//  IDLE    | waiting for a button press, ball frozen
//  PLAY    | ball moving, hit/miss pulses are scored
//  NEWBALL | ball frozen for SERVE_FRAMES frame ticks after a miss
//  OVER    | game over shown for OVER_FRAMES frame ticks, score held
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         btn,
  input  logic               hit,
  input  logic               miss,
  output logic               frame_tick,
  output logic               still,
  output logic               ball_init,
  output logic [1:0]         lives,
  output logic [DIGIT_W-1:0] score_tens,
  output logic [DIGIT_W-1:0] score_ones,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam int unsigned FRAME_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int unsigned FW        = $clog2(FRAME_MAX + 1);
  localparam logic [FW-1:0] SERVE_TC = FW'(SERVE_FRAMES);
  localparam logic [FW-1:0] OVER_TC  = FW'(OVER_FRAMES);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  logic          tick;
  state_e        state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          btn_q, btn_d;
  logic [1:0]    lives_q, lives_d;
  score_t        score_q, score_d;
  logic          still_q, still_d;
  logic          ball_init_q, ball_init_d;
  logic          game_over_q, game_over_d;

  logic          press;
  logic [FW-1:0] frame_term;
  logic [FW-1:0] frame_cnt_inc;

  pong_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (tick)
  );

  // Frame counter only advances in the timed states; elsewhere it sits at 0.
  always_comb begin
    frame_term = '0;
    case (state_q)
      ST_NEWBALL: frame_term = SERVE_TC;
      ST_OVER:    frame_term = OVER_TC;
      default:    frame_term = '0;
    endcase
    frame_cnt_inc = (tick && (frame_cnt_q < frame_term)) ? frame_cnt_q + FW'(1) : frame_cnt_q;
  end

  always_comb begin
    press       = (|btn) & ~btn_q;
    btn_d       = |btn;
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    ball_init_d = 1'b0;
    frame_cnt_d = frame_cnt_inc;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d     = ST_PLAY;
          lives_d     = LIVES_INIT;
          score_d     = '0;
          ball_init_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // A simultaneous hit is discarded when the ball is missed.
        if (miss) begin
          if (lives_q > 2'd1) begin
            state_d     = ST_NEWBALL;
            lives_d     = lives_q - 2'd1;
            ball_init_d = 1'b1;
          end else begin
            state_d = ST_OVER;
            lives_d = 2'd0;
          end
        end else if (hit) begin
          score_d = bcd_inc(score_q);
        end
      end
      ST_NEWBALL: begin
        if (frame_cnt_inc >= SERVE_TC) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (frame_cnt_inc >= OVER_TC) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) frame_cnt_d = '0;

    still_d     = (state_d != ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      btn_q       <= 1'b0;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      still_q     <= 1'b1;
      ball_init_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      btn_q       <= btn_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      still_q     <= still_d;
      ball_init_q <= ball_init_d;
      game_over_q <= game_over_d;
    end
  end

  assign frame_tick = tick;
  assign still      = still_q;
  assign ball_init  = ball_init_q;
  assign lives      = lives_q;
  assign score_tens = score_q.tens;
  assign score_ones = score_q.ones;
  assign state      = state_q;
  assign game_over  = game_over_q;

endmodule
